// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: convolution FSM encodings and default datapath sizes.
package lenet_pkg;

   localparam int unsigned DATA_WIDTH_DEF      = 12;
   localparam int unsigned FRACTIONAL_BITS_DEF = 8;
   localparam int unsigned KERNEL_TAPS_DEF     = 25;
   localparam int unsigned ACC_WIDTH_DEF       = 20;

   typedef enum logic [3:0] {
      IDLE        = 4'b0001,
      LOAD_W      = 4'b0010,
      CALCULATION = 4'b0100,
      DONE        = 4'b1000
   } conv_state_t;

endpackage

// File: rtl/tap_weight_bank.sv
// Kernel weight register file: synchronous write, asynchronous (combinational) read.
module tap_weight_bank
   import lenet_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter  int unsigned KERNEL_TAPS = KERNEL_TAPS_DEF,
   localparam int unsigned ADDR_W      = $clog2(KERNEL_TAPS)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data_c
);

   logic [DATA_WIDTH-1:0] mem [KERNEL_TAPS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/conv_tap_sequencer.sv
// Sequences one convolution window through an external multiplier and accumulates a saturated sum.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module conv_tap_sequencer
   import lenet_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned FRACTIONAL_BITS = FRACTIONAL_BITS_DEF,
   parameter int unsigned KERNEL_TAPS     = KERNEL_TAPS_DEF,
   parameter int unsigned ACC_WIDTH       = ACC_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  reuse_w,
   input  logic                  w_valid,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] mult_a,
   output logic [DATA_WIDTH-1:0] mult_b,
   input  logic [DATA_WIDTH-1:0] mult_p,
   output logic                  busy,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int unsigned IDX_W  = $clog2(KERNEL_TAPS + 1);
   localparam int unsigned ADDR_W = $clog2(KERNEL_TAPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_TAPS - 1);
   localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(KERNEL_TAPS);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({(DATA_WIDTH-1){1'b1}});
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   // Products are already in the operand Q format, so the fraction point never moves.
   if (FRACTIONAL_BITS >= DATA_WIDTH || ACC_WIDTH < DATA_WIDTH) begin : g_bad_cfg
      $error("conv_tap_sequencer: invalid FRACTIONAL_BITS/ACC_WIDTH for DATA_WIDTH");
   end

   conv_state_t                  state_q, state_d;
   logic [IDX_W-1:0]             w_idx_q, w_idx_d;
   logic [IDX_W-1:0]             tap_idx_q, tap_idx_d;
   logic                         loaded_q, loaded_d;
   logic                         v1_q, v1_d, v2_q, v2_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         accept_c, w_we_c;
   logic [DATA_WIDTH-1:0]        w_rd_c, sat_c, res_c;

   tap_weight_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .KERNEL_TAPS (KERNEL_TAPS)
   ) u_bank (
      .clk       (clk),
      .wr_en     (w_we_c),
      .wr_addr   (ADDR_W'(w_idx_q)),
      .wr_data   (w_data),
      .rd_addr   (ADDR_W'(tap_idx_q)),
      .rd_data_c (w_rd_c)
   );

   // Next-state, index and accumulator update.
   always_comb begin
      state_d   = state_q;
      w_idx_d   = w_idx_q;
      tap_idx_d = tap_idx_q;
      loaded_d  = loaded_q;
      acc_d     = acc_q;
      v1_d      = 1'b0;
      v2_d      = v1_q;
      accept_c  = 1'b0;
      w_we_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (reuse_w && loaded_q) begin
                  state_d   = CALCULATION;
                  tap_idx_d = '0;
                  acc_d     = '0;
               end else begin
                  state_d = LOAD_W;
                  w_idx_d = '0;
               end
            end
         end
         LOAD_W: begin
            if (w_valid) begin
               w_we_c  = 1'b1;
               w_idx_d = w_idx_q + IDX_W'(1);
               if (w_idx_q == LAST_IDX) begin
                  state_d   = CALCULATION;
                  loaded_d  = 1'b1;
                  tap_idx_d = '0;
                  acc_d     = '0;
               end
            end
         end
         CALCULATION: begin
            if (in_valid && tap_idx_q != END_IDX) begin
               accept_c  = 1'b1;
               v1_d      = 1'b1;
               tap_idx_d = tap_idx_q + IDX_W'(1);
            end
            if (v2_q) acc_d = acc_q + ACC_WIDTH'($signed(mult_p));
            // Last product lands when every tap is taken and nothing is left in flight behind it.
            if (v2_q && !v1_q && tap_idx_q == END_IDX) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (acc_d > SAT_MAX)      sat_c = SAT_MAX[DATA_WIDTH-1:0];
      else if (acc_d < SAT_MIN) sat_c = SAT_MIN[DATA_WIDTH-1:0];
      else                      sat_c = acc_d[DATA_WIDTH-1:0];
   end

`ifdef CONV_RELU_EN
   assign res_c = sat_c[DATA_WIDTH-1] ? '0 : sat_c;
`else
   assign res_c = sat_c;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         w_idx_q   <= '0;
         tap_idx_q <= '0;
         loaded_q  <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         acc_q     <= '0;
         mult_a    <= '0;
         mult_b    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state_q   <= state_d;
         w_idx_q   <= w_idx_d;
         tap_idx_q <= tap_idx_d;
         loaded_q  <= loaded_d;
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         acc_q     <= acc_d;
         busy      <= (state_d != IDLE);
         out_valid <= (state_d == DONE);
         if (state_d == DONE) out_data <= res_c;
         if (accept_c) begin
            mult_a <= in_data;
            mult_b <= w_rd_c;
         end
      end
   end

endmodule

// File: doc/conv_tap_sequencer.md
CONV_TAP_SEQUENCER -- requirements
Module: conv_tap_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: signed fixed-point operand/result width.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 8: fraction bits of every operand and result.
REQ-003 SHALL have parameter KERNEL_TAPS, default 25: taps per window (5x5).
REQ-004 SHALL have parameter ACC_WIDTH, default 20: internal signed accumulator width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk (in, 1) is the clock and rst (in, 1) is the reset.
REQ-006 SHALL have the following ports, one per line: name, direction, width, meaning.
- start  in  1  begins a window; sampled in IDLE only.
- reuse_w  in  1  sampled with start; 1 skips weight load.
- w_valid  in  1  weight beat valid in LOAD_W.
- w_data  in  DATA_WIDTH  signed weight.
- in_valid  in  1  input tap valid in CALCULATION.
- in_data  in  DATA_WIDTH  signed activation.
- mult_a  out  DATA_WIDTH  registered activation to the multiplier cell.
- mult_b  out  DATA_WIDTH  registered weight to the multiplier cell.
- mult_p  in  DATA_WIDTH  multiplier product, one cycle after mult_a/mult_b.
- busy  out  1  high in any state except IDLE.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  DATA_WIDTH  saturated window sum.

Function
REQ-007 SHALL implement a one-hot FSM: IDLE=0001, LOAD_W=0010, CALCULATION=0100, DONE=1000.
REQ-008 IDLE, start=1, reuse_w=0: SHALL go to LOAD_W and clear the weight index.
REQ-009 IDLE, start=1, reuse_w=1: SHALL go directly to CALCULATION with the stored weights, provided at least one load has completed since reset; otherwise SHALL treat it as reuse_w=0.
REQ-010 LOAD_W: each w_valid beat SHALL write w_data to weight[index] and increment the index; the beat at index KERNEL_TAPS-1 SHALL move the FSM to CALCULATION.
REQ-011 CALCULATION: each in_valid beat at tap index i SHALL register mult_a=in_data and mult_b=weight[i] at that edge; gaps in in_valid SHALL stall without corrupting state.
REQ-012 A beat accepted at edge k SHALL be added to the accumulator from mult_p at edge k+2; a delayed valid shift register tracks this.
REQ-013 The accumulator SHALL clear when CALCULATION is entered; the sum SHALL be a sign-extended ACC_WIDTH sum with no wrap for default parameters.
REQ-014 After the final tap's accumulation at edge k+2, the FSM SHALL enter DONE; in_valid in CALCULATION after the final tap is accepted SHALL be ignored.
REQ-015 DONE SHALL last exactly one cycle with out_valid=1 and out_data = the accumulator saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; the FSM then returns to IDLE.
REQ-016 out_data SHALL hold its value until the next DONE.
REQ-017 start outside IDLE, w_valid outside LOAD_W, and in_valid outside CALCULATION SHALL be ignored.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, with busy, out_valid, out_data, mult_a, mult_b, the accumulator, the indices and the weights-loaded flag at 0.
REQ-019 Reset mid-LOAD_W or mid-CALCULATION SHALL abort the window with no out_valid; the weight contents become don't-care.

Configuration
REQ-020 With CONV_RELU_EN defined, out_data SHALL be max(0, saturated sum). Without it, the signed saturated sum SHALL be output unchanged.

Structure
REQ-021 The state encodings, the default widths and KERNEL_TAPS SHALL live in a shared package, lenet_pkg.
REQ-022 The weight store SHALL be a sub-module, tap_weight_bank: a KERNEL_TAPS x DATA_WIDTH register file with synchronous write and asynchronous read.
REQ-023 The multiplier cell SHALL stay external and be connected via mult_a, mult_b and mult_p.

Verification
REQ-024 Weights all 0x100 (1.0), inputs all 0x010, back-to-back in_valid -> out_valid 27 cycles after the first input beat, out_data=400 (0x190).
REQ-025 Weights all 0x100, inputs all 0x100 -> sum 6400 saturates to out_data=2047 (0x7FF).
REQ-026 Weights all 0x100, inputs all 0xF00 (-1.0) -> out_data=-2048 (0x800); with CONV_RELU_EN, out_data=0.
REQ-027 Second window with reuse_w=1 and inputs all 0x020 -> no LOAD_W cycles, out_data=800 (0x320).
REQ-028 in_valid toggled 1/0 -> same result as the back-to-back case, out_valid delayed by the gap count.
REQ-029 rst asserted at tap 12 of CALCULATION -> immediate IDLE with all outputs 0 and no out_valid; reuse_w=1 after that reset triggers LOAD_W.
